// File: rtl/quad_input_filter_if.sv
// Peripheral read/write bus shared by the quadrature filter and the step counter.
// The master drives address, strobes and write data; the slave returns registered read data.
interface quad_input_filter_if;
   logic [15:0] addr;
   logic        cs;
   logic        rd;
   logic        wr;
   logic [7:0]  data_in;
   logic [7:0]  data_out;

   modport master (
      output addr,
      output cs,
      output rd,
      output wr,
      output data_in,
      input  data_out
   );

   modport slave (
      input  addr,
      input  cs,
      input  rd,
      input  wr,
      input  data_in,
      output data_out
   );
endinterface

// File: rtl/quad_input_filter.sv
// Quadrature pin conditioner: 2-flop sync, per-channel glitch filter, illegal-transition detect.
// Optional interrupt output enabled by defining QIF_IRQ_EN.
module quad_input_filter #(
   parameter int unsigned FILT_DEFAULT = 4,
   parameter logic [15:0] BASE_ADDR    = 16'h0010
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               a_raw,
   input  logic               b_raw,
   quad_input_filter_if.slave bus,
   output logic               a_out,
   output logic               b_out,
`ifdef QIF_IRQ_EN
   output logic               irq,
`endif
   output logic               err_flag
);

   localparam logic [7:0] FILT_RST = 8'(FILT_DEFAULT);

   logic       a_s1_q, a_s2_q, b_s1_q, b_s2_q;
   logic [7:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
   logic       a_out_q, a_out_d, b_out_q, b_out_d;
   logic [7:0] filt_len_q, filt_len_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       err_flag_q, err_flag_d;
   logic [7:0] dout_q, dout_d;
   logic       irq_en_q, irq_en_d;

   logic [15:0] off;
   logic        hit;
   logic        wr_filt, wr_stat, clr_err;
   logic        a_upd, b_upd, illegal;
   logic [7:0]  len_m1;
   logic [7:0]  status;

   assign off     = bus.addr - BASE_ADDR;
   assign hit     = bus.cs && (off < 16'd3);
   assign wr_filt = hit && bus.wr && (off == 16'd0);
   assign wr_stat = hit && bus.wr && (off == 16'd1);
   assign clr_err = wr_stat && bus.data_in[7];
   assign len_m1  = filt_len_q - 8'd1;
   assign status  = {err_flag_q, irq_en_q, 4'b0000, b_out_q, a_out_q};

   // A filt_len write restarts both counts and suppresses any update on that edge.
   assign a_upd   = (a_s2_q != a_out_q) && (a_cnt_q == len_m1) && !wr_filt;
   assign b_upd   = (b_s2_q != b_out_q) && (b_cnt_q == len_m1) && !wr_filt;
   assign illegal = a_upd && b_upd;

   always_comb begin
      a_out_d = a_out_q;
      a_cnt_d = a_cnt_q + 8'd1;
      if (wr_filt || (a_s2_q == a_out_q)) begin
         a_cnt_d = 8'd0;
      end else if (a_upd) begin
         a_out_d = a_s2_q;
         a_cnt_d = 8'd0;
      end
   end

   always_comb begin
      b_out_d = b_out_q;
      b_cnt_d = b_cnt_q + 8'd1;
      if (wr_filt || (b_s2_q == b_out_q)) begin
         b_cnt_d = 8'd0;
      end else if (b_upd) begin
         b_out_d = b_s2_q;
         b_cnt_d = 8'd0;
      end
   end

   // An illegal event on the same edge as a clear wins: the clear is folded into the increment.
   always_comb begin
      err_flag_d = err_flag_q;
      err_cnt_d  = err_cnt_q;
      if (illegal) begin
         err_flag_d = 1'b1;
         if (clr_err) begin
            err_cnt_d = 8'd1;
         end else if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end else if (clr_err) begin
         err_flag_d = 1'b0;
         err_cnt_d  = 8'd0;
      end
   end

   always_comb begin
      filt_len_d = filt_len_q;
      if (wr_filt) begin
         filt_len_d = (bus.data_in == 8'd0) ? 8'd1 : bus.data_in;
      end
   end

`ifdef QIF_IRQ_EN
   always_comb begin
      irq_en_d = irq_en_q;
      if (wr_stat) begin
         irq_en_d = bus.data_in[6];
      end
   end
`else
   assign irq_en_d = 1'b0;
`endif

   // Read data reflects the pre-write register values when rd and wr coincide.
   always_comb begin
      dout_d = 8'h00;
      if (hit && bus.rd) begin
         case (off[1:0])
            2'd0:    dout_d = filt_len_q;
            2'd1:    dout_d = status;
            2'd2:    dout_d = err_cnt_q;
            default: dout_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_s1_q     <= 1'b0;
         a_s2_q     <= 1'b0;
         b_s1_q     <= 1'b0;
         b_s2_q     <= 1'b0;
         a_cnt_q    <= 8'd0;
         b_cnt_q    <= 8'd0;
         a_out_q    <= 1'b0;
         b_out_q    <= 1'b0;
         filt_len_q <= FILT_RST;
         err_cnt_q  <= 8'd0;
         err_flag_q <= 1'b0;
         dout_q     <= 8'h00;
         irq_en_q   <= 1'b0;
      end else begin
         a_s1_q     <= a_raw;
         a_s2_q     <= a_s1_q;
         b_s1_q     <= b_raw;
         b_s2_q     <= b_s1_q;
         a_cnt_q    <= a_cnt_d;
         b_cnt_q    <= b_cnt_d;
         a_out_q    <= a_out_d;
         b_out_q    <= b_out_d;
         filt_len_q <= filt_len_d;
         err_cnt_q  <= err_cnt_d;
         err_flag_q <= err_flag_d;
         dout_q     <= dout_d;
         irq_en_q   <= irq_en_d;
      end
   end

`ifdef QIF_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= err_flag_q & irq_en_q;
      end
   end

   assign irq = irq_q;
`endif

   assign a_out        = a_out_q;
   assign b_out        = b_out_q;
   assign err_flag     = err_flag_q;
   assign bus.data_out = dout_q;

endmodule

// File: doc/quad_input_filter.md
Name: quad_input_filter

Overview:
- Front-end conditioner for raw quadrature encoder pins; sits directly upstream of the step counter and drives its A/B inputs.
- Synchronises both channels to clk and rejects glitches shorter than a programmable number of cycles.
- Flags illegal transitions, where both channels change on the same edge.
- Exposes configuration and error status on the same 8-bit peripheral read/write bus used by the counter.

Parameters:
- FILT_DEFAULT, 4: reset value of the filter-length register. Legal range 1..255.
- BASE_ADDR, 16'h0010: bus address of register 0. The block decodes BASE_ADDR..BASE_ADDR+2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- a_raw  input  1  asynchronous encoder channel A pin
- b_raw  input  1  asynchronous encoder channel B pin
- addr  input  16  bus address
- cs  input  1  bus chip select
- rd  input  1  read strobe
- wr  input  1  write strobe
- data_in  input  8  write data
- data_out  output  8  registered read data
- a_out  output  1  filtered channel A, feeds the counter A input
- b_out  output  1  filtered channel B, feeds the counter B input
- err_flag  output  1  sticky illegal-transition flag

Behaviour:
- Reset (asynchronous, all state):
  - a_out=0, b_out=0, err_flag=0, data_out=8'h00.
  - Sync flops and both stability counters cleared.
  - filt_len=FILT_DEFAULT; err_cnt=0.
- Synchroniser: 2 flops per channel (s1, s2). The filter acts only on s2.
- Per-channel filter (8-bit counter cnt):
  - If s2==out: cnt<=0.
  - If s2!=out and cnt==filt_len-1: out<=s2, cnt<=0.
  - Otherwise: cnt<=cnt+1.
- Latency: a raw level held stable appears on out at clock edge filt_len+2 after it is first sampled. With filt_len=1 this is 3 edges.
- Glitch rejection: a pulse that reaches s2 for fewer than filt_len consecutive cycles never reaches out.
- Illegal event:
  - Occurs when a_out and b_out both update on the same edge.
  - Both outputs still update.
  - err_flag<=1; err_cnt<=err_cnt+1, saturating at 255.
- Register map (offset from BASE_ADDR):
  - 0: filt_len, R/W.
  - 1: status. Read returns {err_flag, 5'b0, b_out, a_out}.
  - 2: err_cnt, read-only.
- Write rules (cs&&wr at an offset, applied on the next edge):
  - Offset 0: filt_len<=data_in; a written 0 stores 1. Both stability counters clear on the same edge.
  - Offset 1 with data_in[7]=1: clears err_flag and err_cnt.
  - Writes to offset 2 and to unmapped addresses are ignored.
- Read rules:
  - cs&&rd at a mapped offset: data_out<=register value on the next edge (1-cycle latency).
  - Unmapped address, or no read: data_out<=8'h00. Never high-Z.
- Simultaneous events:
  - Clear write and illegal event on the same edge: the event wins. Result is err_flag=1, err_cnt=1.
  - filt_len write while a count is in progress: the count restarts under the new length.
- cs&&rd&&wr together: the write is performed and the read returns the pre-write value.

Optional Feature:
- Macro: QIF_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit).
  - Adds irq_en at status bit 6, written by a write to offset 1. Reset value 0.
  - irq = err_flag & irq_en, registered. Reset value 0.
  - Status read returns irq_en in bit 6.
- When undefined:
  - No irq port.
  - Bit 6 reads 0 and writes to it are ignored.

Test Plan:
- Reset, then hold a_raw=1 from edge 0 with filt_len=4: a_out rises at edge 6; b_out stays 0; err_flag=0.
- filt_len=4, a_raw pulses high for 3 cycles: a_out never changes; read of offset 1 returns 8'h00.
- Write 0 to offset 0, then read offset 0: returns 8'h01. A 1-cycle-wide stable level then propagates in 3 edges.
- Toggle a_raw and b_raw on the same cycle with filt_len=2: both outputs flip on the same edge; err_flag=1; offset 2 reads 8'h01. Repeat 300 times: offset 2 reads 8'hFF.
- Write 8'h80 to offset 1 on the same edge as an illegal event: err_flag=1 and err_cnt=1. An isolated write of 8'h80 clears both to 0.
- Assert rst_n low mid-count (cnt=2, a_out=1): all outputs and registers return to reset values immediately. filt_len reads back FILT_DEFAULT.
